// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner and its
// decimal entry accumulator.
package keypad_pkg;

  localparam logic [3:0] KEY_BKSP  = 4'hE;
  localparam logic [3:0] KEY_CLR   = 4'hC;
  localparam logic [3:0] KEY_ENTER = 4'hF;
  localparam int unsigned MAX_ENTRY = 9999;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESSED = 1'b1
  } kp_state_e;

  // Per-scan candidate: vld=0 means no key; idx = {row, col}
  typedef struct packed {
    logic       vld;
    logic [3:0] idx;
  } kp_cand_t;

  function automatic logic [3:0] key_map(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h2;
      4'd2:    code = 4'h3;
      4'd3:    code = 4'hA;
      4'd4:    code = 4'h4;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h6;
      4'd7:    code = 4'hB;
      4'd8:    code = 4'h7;
      4'd9:    code = 4'h8;
      4'd10:   code = 4'h9;
      4'd11:   code = 4'hC;
      4'd12:   code = 4'hE;
      4'd13:   code = 4'h0;
      4'd14:   code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_decimal_entry.sv
// Decimal entry accumulator: builds a 0..9999 value from digit keys, with
// backspace, clear and enter-latch.
module keypad_decimal_entry
  import keypad_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid_i,
  input  logic [3:0]  key_code_i,
  output logic [13:0] value_o,
  output logic [13:0] entered_o,
  output logic        enter_pulse_o
);

  logic [13:0] value_q, entered_q;
  logic        enter_pulse_q;
  logic [16:0] shifted;

  assign shifted = {3'b0, value_q} * 17'd10 + {13'b0, key_code_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q       <= '0;
      entered_q     <= '0;
      enter_pulse_q <= 1'b0;
    end else begin
      enter_pulse_q <= 1'b0;
      if (key_valid_i) begin
        case (key_code_i)
          4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
          4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
            // A fifth digit is dropped rather than wrapping past MAX_ENTRY
            if (value_q <= 14'(MAX_ENTRY / 10)) value_q <= shifted[13:0];
          end
          KEY_BKSP:  value_q <= value_q / 14'd10;
          KEY_CLR:   value_q <= '0;
          KEY_ENTER: begin
            entered_q     <= value_q;
            enter_pulse_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign value_o       = value_q;
  assign entered_o     = entered_q;
  assign enter_pulse_o = enter_pulse_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column strobe, row sync, ghost-rejecting
// debounce and one-cycle key events feeding a decimal entry accumulator.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 131072,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  col,
  input  logic [3:0]  row,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_held,
  output logic [13:0] value,
  output logic [13:0] entered,
  output logic        enter_pulse
);

  localparam int DW_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  logic [1:0][3:0]  row_sync_q;
  logic [3:0]       row_s;
  logic [DW_W-1:0]  dwell_q;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [3:0]       col_q;
  logic [15:0]      snap_q, snap_full;
  logic             last_dwell, scan_end;

  logic [4:0]       ones;
  logic [3:0]       hit_idx;
  logic             ghost;
  kp_cand_t         cand, prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable, accept, release_key;
  logic [3:0]       code_new;

  kp_state_e        state_q;
  logic             key_valid_q, key_held_q;
  logic [3:0]       key_code_q;

  assign row_s      = row_sync_q[1];
  assign last_dwell = (dwell_q == DW_W'(SCAN_DIV - 1));
  assign scan_end   = last_dwell && (col_idx_q == 2'd3);
  assign col_idx_d  = last_dwell ? col_idx_q + 2'd1 : col_idx_q;

  always_comb begin
    snap_full = snap_q;
    if (last_dwell)
      for (int r = 0; r < 4; r++) snap_full[{2'(r), col_idx_q}] = ~row_s[r];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_sync_q <= '1;
      dwell_q    <= '0;
      col_idx_q  <= '0;
      col_q      <= 4'b1111;
      snap_q     <= '0;
    end else begin
      row_sync_q <= {row_sync_q[0], row};
      dwell_q    <= last_dwell ? '0 : dwell_q + DW_W'(1);
      col_idx_q  <= col_idx_d;
      col_q      <= ~(4'b0001 << col_idx_d);
      snap_q     <= scan_end ? '0 : snap_full;
    end
  end

  // Candidate extraction: more than one closed switch is treated as ghosting
  always_comb begin
    ones    = '0;
    hit_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (snap_full[i]) begin
        ones    = ones + 5'd1;
        hit_idx = 4'(i);
      end
    end
  end

  assign ghost    = (ones > 5'd1);
  assign cand     = '{vld: (ones == 5'd1), idx: (ones == 5'd1) ? hit_idx : 4'd0};
  assign code_new = key_map(cand.idx);

  always_comb begin
    cnt_d  = cnt_q;
    prev_d = prev_q;
    if (scan_end && !ghost) begin
      if (cand == prev_q) begin
        if (cnt_q != CNT_W'(DEBOUNCE_SCANS)) cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d  = CNT_W'(1);
        prev_d = cand;
      end
    end
  end

  assign stable      = scan_end && !ghost && (cnt_d == CNT_W'(DEBOUNCE_SCANS));
  assign accept      = stable && cand.vld &&
                       ((state_q == IDLE) || (code_new != key_code_q));
  assign release_key = stable && !cand.vld && (state_q == PRESSED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      prev_q      <= '0;
      state_q     <= IDLE;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      key_held_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      prev_q      <= prev_d;
      key_valid_q <= accept;
      case (state_q)
        IDLE: if (accept) begin
          state_q    <= PRESSED;
          key_code_q <= code_new;
          key_held_q <= 1'b1;
        end
        PRESSED: begin
          if (accept) key_code_q <= code_new;
          else if (release_key) begin
            state_q    <= IDLE;
            key_held_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Fed from the pre-register accept so value moves on the key_valid edge
  keypad_decimal_entry u_entry (
    .clk           (clk),
    .rst           (rst),
    .key_valid_i   (accept),
    .key_code_i    (code_new),
    .value_o       (value),
    .entered_o     (entered),
    .enter_pulse_o (enter_pulse)
  );

  assign col       = col_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 switch matrix.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  col, row;
  logic        key_valid, key_held, enter_pulse;
  logic [3:0]  key_code;
  logic [13:0] value, entered;
  logic [15:0] pressed = '0;

  int checks = 0;
  int errors = 0;
  int kv_cnt = 0;
  int ep_cnt = 0;
  logic [3:0] last_code = '0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .col         (col),
    .row         (row),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_held    (key_held),
    .value       (value),
    .entered     (entered),
    .enter_pulse (enter_pulse)
  );

  always #5 clk = ~clk;

  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[4*r+c] && !col[c]) row[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_valid) begin
      kv_cnt    = kv_cnt + 1;
      last_code = key_code;
    end
    if (enter_pulse) ep_cnt = ep_cnt + 1;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    pressed = '0;
    @(negedge clk); rst = 1'b1;
    cycles(2);
    rst = 1'b0;
  endtask

  task automatic tap(input int idx);
    pressed[idx] = 1'b1;
    cycles(80);
    pressed[idx] = 1'b0;
    cycles(80);
  endtask

  task automatic test_reset();
    cycles(2);
    checks++; if (col !== 4'b1111) begin errors++; $display("FAIL reset_col got %b exp 1111", col); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_kv got %b exp 0", key_valid); end
    checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL reset_code got %h exp 0", key_code); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held got %b exp 0", key_held); end
    checks++; if (value !== 14'd0) begin errors++; $display("FAIL reset_value got %0d exp 0", value); end
    checks++; if (entered !== 14'd0) begin errors++; $display("FAIL reset_entered got %0d exp 0", entered); end
    checks++; if (enter_pulse !== 1'b0) begin errors++; $display("FAIL reset_ep got %b exp 0", enter_pulse); end
    rst = 1'b0;
  endtask

  // Must run immediately after test_reset releases rst
  task automatic test_idle_scan();
    logic [3:0] one, exp;
    int base;
    one  = 4'b0001;
    base = kv_cnt;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      exp = ~(one << ((n / 4) % 4));
      checks++;
      if (col !== exp) begin errors++; $display("FAIL idle_col cyc %0d got %b exp %b", n, col, exp); end
    end
    checks++; if (kv_cnt != base) begin errors++; $display("FAIL idle_kv got %0d exp 0 pulses", kv_cnt - base); end
    checks++; if (value !== 14'd0) begin errors++; $display("FAIL idle_value got %0d exp 0", value); end
  endtask

  task automatic test_press5();
    int base, lat;
    bit found;
    do_reset();
    base  = kv_cnt;
    found = 0;
    lat   = 0;
    pressed[5] = 1'b1;
    while (!found && lat < 60) begin
      @(negedge clk);
      lat++;
      if (key_valid) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL press5_timeout got none exp pulse within 60"); end
    checks++; if (key_code !== 4'h5) begin errors++; $display("FAIL press5_code got %h exp 5", key_code); end
    checks++; if (value !== 14'd5) begin errors++; $display("FAIL press5_value got %0d exp 5", value); end
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL press5_held got %b exp 1", key_held); end
    cycles(100 - lat);
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL press5_held100 got %b exp 1", key_held); end
    checks++; if (kv_cnt - base != 1) begin errors++; $display("FAIL press5_pulses got %0d exp 1", kv_cnt - base); end
    pressed[5] = 1'b0;
    cycles(80);
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL press5_release got %b exp 0", key_held); end
    checks++; if (kv_cnt - base != 1) begin errors++; $display("FAIL press5_norepeat got %0d exp 1", kv_cnt - base); end
    checks++; if (value !== 14'd5) begin errors++; $display("FAIL press5_value_end got %0d exp 5", value); end
  endtask

  task automatic test_entry();
    int ep_base;
    do_reset();
    tap(0);  checks++; if (value !== 14'd1)    begin errors++; $display("FAIL entry_1 got %0d exp 1", value); end
    tap(1);  checks++; if (value !== 14'd12)   begin errors++; $display("FAIL entry_12 got %0d exp 12", value); end
    tap(2);  checks++; if (value !== 14'd123)  begin errors++; $display("FAIL entry_123 got %0d exp 123", value); end
    tap(4);  checks++; if (value !== 14'd1234) begin errors++; $display("FAIL entry_1234 got %0d exp 1234", value); end
    tap(5);  checks++; if (value !== 14'd1234) begin errors++; $display("FAIL entry_full got %0d exp 1234", value); end
    tap(12); checks++; if (value !== 14'd123)  begin errors++; $display("FAIL entry_bksp got %0d exp 123", value); end
    ep_base = ep_cnt;
    tap(14);
    checks++; if (entered !== 14'd123) begin errors++; $display("FAIL entry_enter got %0d exp 123", entered); end
    checks++; if (ep_cnt - ep_base != 1) begin errors++; $display("FAIL entry_pulse got %0d exp 1", ep_cnt - ep_base); end
    checks++; if (value !== 14'd123) begin errors++; $display("FAIL entry_keep got %0d exp 123", value); end
    tap(11);
    checks++; if (value !== 14'd0) begin errors++; $display("FAIL entry_clr got %0d exp 0", value); end
    checks++; if (entered !== 14'd123) begin errors++; $display("FAIL entry_clr_entered got %0d exp 123", entered); end
  endtask

  task automatic test_bounce();
    int base;
    do_reset();
    base = kv_cnt;
    for (int k = 0; k < 6; k++) begin
      pressed[0] = (k % 2 == 0);
      cycles(16);
    end
    checks++; if (kv_cnt != base) begin errors++; $display("FAIL bounce_quiet got %0d exp 0 pulses", kv_cnt - base); end
    pressed[0] = 1'b1;
    cycles(80);
    checks++; if (kv_cnt - base != 1) begin errors++; $display("FAIL bounce_accept got %0d exp 1 pulse", kv_cnt - base); end
    checks++; if (last_code !== 4'h1) begin errors++; $display("FAIL bounce_code got %h exp 1", last_code); end
    pressed = '0;
    cycles(80);
  endtask

  task automatic test_ghost();
    int base;
    do_reset();
    base    = kv_cnt;
    pressed = 16'h0021;
    cycles(100);
    checks++; if (kv_cnt != base) begin errors++; $display("FAIL ghost_reject got %0d exp 0 pulses", kv_cnt - base); end
    pressed = 16'h0001;
    cycles(80);
    checks++; if (kv_cnt - base != 1) begin errors++; $display("FAIL ghost_release got %0d exp 1 pulse", kv_cnt - base); end
    checks++; if (last_code !== 4'h1) begin errors++; $display("FAIL ghost_code got %h exp 1", last_code); end
    pressed = '0;
    cycles(80);
  endtask

  task automatic test_reset_mid();
    int n;
    bit found;
    do_reset();
    pressed[5] = 1'b1;
    cycles(60);
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL rstmid_pre got %b exp 1", key_held); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (col !== 4'b1111) begin errors++; $display("FAIL rstmid_col got %b exp 1111", col); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL rstmid_held got %b exp 0", key_held); end
    checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL rstmid_code got %h exp 0", key_code); end
    checks++; if (value !== 14'd0) begin errors++; $display("FAIL rstmid_value got %0d exp 0", value); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rstmid_kv got %b exp 0", key_valid); end
    @(negedge clk);
    rst   = 1'b0;
    found = 0;
    n     = 0;
    while (!found && n < 60) begin
      @(negedge clk);
      n++;
      if (key_valid) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL rstmid_repress got none exp pulse within 60"); end
    checks++; if (key_code !== 4'h5) begin errors++; $display("FAIL rstmid_code2 got %h exp 5", key_code); end
    checks++; if (value !== 14'd5) begin errors++; $display("FAIL rstmid_value2 got %0d exp 5", value); end
    pressed = '0;
    cycles(80);
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_press5();
    test_entry();
    test_bounce();
    test_ghost();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Input-side companion to the 4-digit seven-segment driver. It scans a 4x4 active-low matrix keypad by strobing columns and sampling rows, the mirror of the display's digit strobing. It debounces key presses and emits one-cycle key events. It also maintains a decimal entry value (0..9999) that can feed the display's number input directly.

Parameters:
SCAN_DIV, 131072, clk cycles each column is driven (about 1.3 ms at 100 MHz); minimum 4.
DEBOUNCE_SCANS, 4, consecutive identical full scans required to accept a press or release; minimum 1.

Ports:
clk  in  1  system clock
rst  in  1  reset
col  out  4  column drive, active-low, one-cold
row  in  4  row sense, active-low (pulled up), asynchronous to clk
key_valid  out  1  one-cycle pulse when a new key is accepted
key_code  out  4  code of last accepted key
key_held  out  1  accepted key still pressed
value  out  14  decimal entry accumulator, 0..9999
entered  out  14  value latched on ENTER
enter_pulse  out  1  one-cycle pulse when entered updates

Behaviour:
- Reset is asynchronous and active-high (rst); the clock is clk. All outputs and state are cleared on reset.
- Reset values: col=4'b1111, key_valid=0, key_code=0, key_held=0, value=0, entered=0, enter_pulse=0, debounce FSM in IDLE, stable count 0, column index 0, dwell counter 0.
- On the first clk edge after reset release, col becomes 4'b1110.
- Row input passes through a 2-flop synchronizer before any use.
- Column scan:
  - col = ~(1<<c), where c cycles 0,1,2,3,0...
  - Dwell counter counts 0..SCAN_DIV-1 per column.
  - Synchronized rows are sampled only on the last dwell cycle, after settling.
  - Sample bit r goes into snapshot[4*r+c].
- End of scan: the cycle in which column 3 is sampled. The snapshot is evaluated there, then cleared for the next scan.
- Candidate per scan:
  - No bits set -> NONE.
  - Exactly one bit set -> that (r,c).
  - Two or more bits set -> scan is discarded: stable count, candidate and FSM all unchanged (ghost rejection).
- Stable count:
  - If the candidate equals the previous candidate, count increments, saturating at DEBOUNCE_SCANS.
  - Otherwise count = 1 and the previous candidate is updated.
- Debounce FSM, evaluated at end of scan after the count update:
  - IDLE -> PRESSED when count == DEBOUNCE_SCANS and candidate is a key. key_valid pulses on the next edge; key_code is set and key_held=1 on that same edge.
  - PRESSED, same key stable: no action. There is no auto-repeat.
  - PRESSED -> IDLE when NONE is stable for DEBOUNCE_SCANS scans; key_held=0.
  - PRESSED, a different key stable for DEBOUNCE_SCANS scans: new key_valid pulse, stay PRESSED.
- Key map (r,c), row 0 top, col 0 left:
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E(*),0,F(#),D
- Latency: a clean press produces key_valid at DEBOUNCE_SCANS full scans after the first scan that sees it, plus 1 cycle.
- Entry accumulator acts on the same edge as key_valid, so value is updated while key_valid is high:
  - Digit 0-9: value = value*10 + d if value <= 999, else ignored. Four digits max; no wrap.
  - E (backspace): value = value/10.
  - C (clear): value = 0.
  - F (enter): entered = value, enter_pulse=1 for one cycle, value unchanged.
  - A, B, D: key_valid only, no accumulator effect.
- Arithmetic uses a 14-bit unsigned result; value*10 is computed at 17 bits, then truncated after the <=999 guard.
- Reset mid-scan or mid-press: everything returns to reset values immediately. A key still held after reset is re-accepted after debounce, giving a fresh pulse.

Decomposition:
- Package keypad_pkg holds:
  - Key code constants: KEY_BKSP=4'hE, KEY_CLR=4'hC, KEY_ENTER=4'hF.
  - The 16-entry (r,c)->code map function.
  - FSM state encoding: IDLE, PRESSED.
  - MAX_ENTRY=9999.
- One natural sub-module: keypad_decimal_entry. It takes key_valid/key_code and owns value, entered and enter_pulse.
- Scan, synchronizer and debounce stay in keypad_scanner.

Test Plan:
Sim parameters SCAN_DIV=4, DEBOUNCE_SCANS=2. The keypad model pulls row[r] low while col[c]==0 and (r,c) is pressed.
- Reset then idle 200 cycles -> col rotates 1110,1101,1011,0111 every 4 cycles; key_valid never asserts; value=0.
- Press (1,1) "5" held 100 cycles -> exactly one key_valid with key_code=5, within 2 scans + 1 cycle (<=40 cycles) of the first sampling scan; key_held=1 until release is debounced; value=5.
- Press 1,2,3,4,5 in sequence with releases -> value goes 1,12,123,1234, then stays 1234. Press * -> 123. Press # -> entered=123 with one enter_pulse. Press C -> value=0, entered stays 123.
- Bounce: toggle (0,0) each scan for 6 scans, then hold -> no key_valid during bounce; one pulse with code 1 after stable.
- Press (0,0) and (1,1) together -> no key_valid. Release (1,1) -> key 1 accepted.
- Assert rst while a key is held mid-dwell -> all outputs return to reset values within one cycle; after release of rst the held key produces a new pulse.
